// File: rtl/pkt_ctrl_pkg.sv
// Shared types and constants for the key-location lookup controller:
// FSM states, register word offsets and STATUS bit positions.
package pkt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_INDEX  = 5'd1;
    localparam logic [4:0] REG_STATUS = 5'd2;
    localparam logic [4:0] REG_LOC    = 5'd3;
    localparam logic [4:0] REG_IRQ_EN = 5'd4;
    localparam logic [4:0] REG_LOCK   = 5'd5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CH_LSB = 8;
    localparam int CH_W        = 3;

endpackage

// File: rtl/pkt_ctrl_regs.sv
// Register bus decode and control/status registers for pkt_ctrl.
// Optional PKT_CTRL_LOCK_EN maps word 5 as a sticky lock on INDEX writes.
module pkt_ctrl_regs
    import pkt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int NUM_KEYS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_valid,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  reg_error,
    input  logic                  busy,
    input  logic                  done_set,
    input  logic [31:0]           loc_value,
    output logic                  start,
    output logic [CH_W-1:0]       start_ch,
    output logic [DATA_WIDTH-1:0] index,
    output logic                  irq
);

    logic [4:0]            word;
    logic [CH_W-1:0]       wr_ch;
    logic                  word_mapped;
    logic                  ch_bad;
    logic                  lock_bit;
    logic                  wr_ok;
    logic                  ctrl_start;
    logic                  index_ok;
    logic                  w1c;
    logic                  err_set;
    logic                  done_next;
    logic                  err_next;
    logic [DATA_WIDTH-1:0] index_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  irq_en_reg;
    logic                  unused_addr;

    assign word        = reg_addr[6:2];
    assign wr_ch       = reg_wdata[CTRL_CH_LSB +: CH_W];
    assign unused_addr = ^{reg_addr[ADDR_WIDTH-1:7], reg_addr[1:0]};

    always_comb begin
        word_mapped = 1'b0;
        case (word)
            REG_CTRL, REG_INDEX, REG_STATUS, REG_LOC, REG_IRQ_EN: word_mapped = 1'b1;
`ifdef PKT_CTRL_LOCK_EN
            REG_LOCK: word_mapped = 1'b1;
`endif
            default: word_mapped = 1'b0;
        endcase
    end

    assign ch_bad = ({29'd0, wr_ch} >= 32'(NUM_CH));

    // Any rejected access leaves every register untouched.
    assign reg_error = reg_valid & (~word_mapped
                     | (reg_write & (word == REG_LOC))
                     | (reg_write & (word == REG_CTRL) & ch_bad)
                     | (reg_write & (word == REG_INDEX) & lock_bit));

    assign wr_ok      = reg_valid & reg_write & ~reg_error;
    assign ctrl_start = wr_ok & (word == REG_CTRL) & reg_wdata[CTRL_START];
    assign index_ok   = (index_reg < DATA_WIDTH'(NUM_KEYS));
    assign start      = ctrl_start & ~busy & index_ok;
    assign err_set    = ctrl_start & (busy | ~index_ok);
    assign start_ch   = wr_ch;
    assign index      = index_reg;
    assign irq        = done_reg & irq_en_reg;

    // A set arriving with a write-1-to-clear in the same cycle wins.
    assign w1c       = wr_ok & (word == REG_STATUS);
    assign done_next = done_set | (done_reg & ~(w1c & reg_wdata[STAT_DONE]));
    assign err_next  = err_set  | (err_reg  & ~(w1c & reg_wdata[STAT_ERR]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
        end else begin
            if (wr_ok && (word == REG_INDEX))
                index_reg <= reg_wdata;
            if (wr_ok && (word == REG_IRQ_EN))
                irq_en_reg <= reg_wdata[0];
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

`ifdef PKT_CTRL_LOCK_EN
    logic lock_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_reg <= 1'b0;
        else if (wr_ok && (word == REG_LOCK) && reg_wdata[0])
            lock_reg <= 1'b1;
    end

    assign lock_bit = lock_reg;
`else
    assign lock_bit = 1'b0;
`endif

    always_comb begin
        reg_rdata = '0;
        case (word)
            REG_INDEX:  reg_rdata = index_reg;
            REG_STATUS: begin
                reg_rdata[STAT_BUSY] = busy;
                reg_rdata[STAT_DONE] = done_reg;
                reg_rdata[STAT_ERR]  = err_reg;
            end
            REG_LOC:    reg_rdata = DATA_WIDTH'(loc_value);
            REG_IRQ_EN: reg_rdata[0] = irq_en_reg;
`ifdef PKT_CTRL_LOCK_EN
            REG_LOCK:   reg_rdata[0] = lock_bit;
`endif
            default:    reg_rdata = '0;
        endcase
    end

endmodule

// File: rtl/pkt_ctrl.sv
// Key-location lookup controller: computes KEY_BASE + index*KEY_STRIDE and
// presents it on a valid/ready channel. Optional lock via PKT_CTRL_LOCK_EN.
module pkt_ctrl
    import pkt_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 2,
    parameter int          NUM_KEYS   = 16,
    parameter logic [31:0] KEY_BASE   = 32'h0000_0000,
    parameter logic [31:0] KEY_STRIDE = 32'h40,
    parameter int          LOOKUP_LAT = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [ADDR_WIDTH-1:0]  reg_addr_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    output logic [DATA_WIDTH-1:0]  reg_rdata_o,
    output logic                   reg_ready_o,
    output logic                   reg_error_o,
    output logic [NUM_CH-1:0]      loc_valid_o,
    input  logic [NUM_CH-1:0]      loc_ready_i,
    output logic [NUM_CH-1:0][31:0] pkey_loc_o,
    output logic                   irq_o
);

    localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOOKUP_LAT - 1);

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CH_W-1:0]       ch_reg;
    logic [31:0]           idx_reg;
    logic [31:0]           loc_reg;
    logic [31:0]           loc_calc;
    logic [NUM_CH-1:0]     ch_hit;
    logic                  calc_done;
    logic                  handshake;
    logic                  busy;
    logic                  start;
    logic [CH_W-1:0]       start_ch;
    logic [DATA_WIDTH-1:0] index;

    assign reg_ready_o = 1'b1;
    assign busy        = (state_reg != ST_IDLE);
    assign loc_calc    = KEY_BASE + idx_reg * KEY_STRIDE;

    pkt_ctrl_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH),
        .NUM_KEYS   (NUM_KEYS)
    ) u_regs (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .reg_valid (reg_valid_i),
        .reg_write (reg_write_i),
        .reg_addr  (reg_addr_i),
        .reg_wdata (reg_wdata_i),
        .reg_rdata (reg_rdata_o),
        .reg_error (reg_error_o),
        .busy      (busy),
        .done_set  (handshake),
        .loc_value (loc_reg),
        .start     (start),
        .start_ch  (start_ch),
        .index     (index),
        .irq       (irq_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        calc_done  = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start)
                    state_next = ST_CALC;
            end
            ST_CALC: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_PRESENT;
                    calc_done  = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (|(loc_ready_i & ch_hit)) begin
                    state_next = ST_IDLE;
                    handshake  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Channel and index are captured at start so bus writes during a lookup cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
            ch_reg  <= '0;
            idx_reg <= '0;
            loc_reg <= '0;
        end else begin
            if (start) begin
                cnt_reg <= '0;
                ch_reg  <= start_ch;
                idx_reg <= 32'(index);
            end else if (state_reg == ST_CALC) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (calc_done)
                loc_reg <= loc_calc;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [31:0] key_reg;
            logic        valid_reg;

            assign ch_hit[gi] = (ch_reg == CH_W'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    key_reg   <= '0;
                    valid_reg <= 1'b0;
                end else if (calc_done && ch_hit[gi]) begin
                    key_reg   <= loc_calc;
                    valid_reg <= 1'b1;
                end else if (handshake && ch_hit[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign pkey_loc_o[gi]  = key_reg;
            assign loc_valid_o[gi] = valid_reg;
        end
    endgenerate

endmodule

// File: doc/pkt_ctrl.md
PKT_CTRL -- requirements
Module: pkt_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, register-bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, register-bus data width.
REQ-003 Parameter NUM_CH, default 2, number of key-location output channels (1..8).
REQ-004 Parameter NUM_KEYS, default 16, number of valid key indices.
REQ-005 Parameter KEY_BASE, default 32'h0000_0000, location of key 0.
REQ-006 Parameter KEY_STRIDE, default 32'h40, byte distance between consecutive keys.
REQ-007 Parameter LOOKUP_LAT, default 2, lookup cycles (>=1).
REQ-008 clk_i  in  1  single clock; all logic on its rising edge.
REQ-009 rst_ni  in  1  reset, asynchronous, active-low.
REQ-010 reg_valid_i  in  1  bus access strobe.
REQ-011 reg_write_i  in  1  1 = write, 0 = read.
REQ-012 reg_addr_i  in  ADDR_WIDTH  byte address; word select addr[6:2].
REQ-013 reg_wdata_i  in  DATA_WIDTH  write data.
REQ-014 reg_rdata_o  out  DATA_WIDTH  combinational read data.
REQ-015 reg_ready_o  out  1  tied 1.
REQ-016 reg_error_o  out  1  combinational access error.
REQ-017 loc_valid_o  out  NUM_CH  per-channel location valid.
REQ-018 loc_ready_i  in  NUM_CH  per-channel consumer ready.
REQ-019 pkey_loc_o  out  NUM_CH x 32  per-channel key location.
REQ-020 irq_o  out  1  level interrupt = done & irq_en.

Function
REQ-021 Register map (addr[6:2]): 0 CTRL (W: bit0 start, bits[10:8] channel), 1 INDEX (RW), 2 STATUS (R: bit0 busy, bit1 done, bit2 err; W1C bits1-2), 3 LOC (R: last computed location), 4 IRQ_EN (RW bit0), 5 LOCK (see Configuration).
REQ-022 Writes/reads to unmapped words, writes to LOC, and CTRL channel >= NUM_CH SHALL assert reg_error_o in the same cycle and change no state.
REQ-023 FSM states IDLE, CALC, PRESENT; reset state IDLE.
REQ-024 IDLE: start write with INDEX < NUM_KEYS -> CALC; busy=1; channel and index latched.
REQ-025 IDLE: start with INDEX >= NUM_KEYS -> stay IDLE; err=1 next cycle; no output change.
REQ-026 CALC: counter runs LOOKUP_LAT cycles, then LOC = KEY_BASE + index*KEY_STRIDE (32-bit, wrap modulo 2^32) -> PRESENT.
REQ-027 PRESENT: pkey_loc_o[ch]=LOC, loc_valid_o[ch]=1, held stable until loc_ready_i[ch]=1; on that edge valid drops, done=1, busy=0, -> IDLE.
REQ-028 Start written while busy SHALL be ignored and set err=1.
REQ-029 INDEX write while busy SHALL be accepted into the register but not affect the in-flight lookup.
REQ-030 Same-cycle done set and W1C clear of done: set wins.
REQ-031 Unselected channels hold previous pkey_loc_o; their loc_valid_o stays 0.
REQ-032 Start to loc_valid_o latency = LOOKUP_LAT+1 cycles.

Reset
REQ-033 rst_ni low SHALL immediately force IDLE, all loc_valid_o=0, pkey_loc_o=0, INDEX=0, LOC=0, STATUS=0, IRQ_EN=0, LOCK=0, irq_o=0, including mid-CALC or mid-PRESENT.

Configuration
REQ-034 Macro PKT_CTRL_LOCK_EN: when defined, LOCK bit0 is write-1-set only; once set, INDEX writes are ignored with reg_error_o=1 until reset.
REQ-035 Without PKT_CTRL_LOCK_EN, word 5 is unmapped (REQ-022).

Structure
REQ-036 Package pkt_ctrl_pkg SHALL hold the FSM state enum, register word-offset constants and STATUS bit positions.
REQ-037 Sub-module pkt_ctrl_regs SHALL implement bus decode and registers; pkt_ctrl holds FSM and channel outputs.

Verification
REQ-038 INDEX=3, start ch0, defaults -> loc_valid_o[0] rises 3 cycles later, pkey_loc_o[0]=32'hC0; ready -> done=1.
REQ-039 INDEX=16 then start -> err=1, loc_valid_o stays 0, STATUS reads 3'b100.
REQ-040 Hold loc_ready_i[1]=0 for 10 cycles on ch1 lookup -> valid/data stable; second start -> err=1.
REQ-041 IRQ_EN=1, complete lookup -> irq_o=1; W1C done -> irq_o=0 next cycle.
REQ-042 Assert rst_ni low during CALC -> all outputs zero asynchronously, IDLE after release.
REQ-043 With PKT_CTRL_LOCK_EN: LOCK=1, write INDEX=5 -> reg_error_o=1, INDEX unchanged.
